// File: rtl/jt49_dly_sched.sv
// jt49_dly_sched
//   Shares one single-port delay RAM between NCH audio channels. Each sample
//   strobe (cen) starts a round. The round visits every channel with one read
//   slot (RD) and one write slot (WR). It then presents all delayed samples
//   together in DONE. Each channel owns a 2**depth-word ring inside the RAM.
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   cen         : sample strobe, starts one round when idle
//   din, dly    : packed per-channel samples and delays (channel k at k*width)
//   dout        : packed delayed samples, updated with dout_valid
//   dout_valid  : one-cycle pulse when dout updates
//   busy        : high while a round is in progress
//   overrun     : sticky flag, cen seen while busy
module jt49_dly_sched #(
  parameter int NCH   = 3,
  parameter int dw    = 8,
  parameter int depth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic [NCH*dw-1:0]    din,
  input  logic [NCH*depth-1:0] dly,
  output logic [NCH*dw-1:0]    dout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW    = CW + depth;
  localparam int WORDS = NCH * (2**depth);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        k_q, k_d;
  logic [NCH*dw-1:0]    din_sh_q, din_sh_d;
  logic [NCH*depth-1:0] dly_sh_q, dly_sh_d;
  logic [NCH*dw-1:0]    out_q, out_d;
  logic [NCH*dw-1:0]    dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic [depth-1:0]     wrpos_q, wrpos_d;
  logic [depth-1:0]     fill_q, fill_d;

  logic [dw-1:0]        mem_q [0:WORDS-1];
  logic [dw-1:0]        rd_data_q;
  logic                 mem_we_s;
  logic                 mem_re_s;
  logic [AW-1:0]        mem_addr_s;
  logic [depth-1:0]     cur_dly_s;
  logic [dw-1:0]        cur_din_s;
  logic [dw-1:0]        new_out_s;

  // Current channel's latched delay and sample.
  always_comb begin
    cur_dly_s = dly_sh_q[int'(k_q)*depth +: depth];
    cur_din_s = din_sh_q[int'(k_q)*dw +: dw];
  end

  // Output selection for the current channel.
  // A delay of zero bypasses the RAM. A delay beyond the written history yields silence.
  always_comb begin
    if (cur_dly_s == {depth{1'b0}}) begin
      new_out_s = cur_din_s;
    end else if (cur_dly_s > fill_q) begin
      new_out_s = {dw{1'b0}};
    end else begin
      new_out_s = rd_data_q;
    end
  end

  // Round scheduler: next state, RAM slot control and output staging.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    din_sh_d     = din_sh_q;
    dly_sh_d     = dly_sh_q;
    out_d        = out_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overrun_d    = overrun_q;
    wrpos_d      = wrpos_q;
    fill_d       = fill_q;
    mem_we_s     = 1'b0;
    mem_re_s     = 1'b0;
    mem_addr_s   = {AW{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (cen) begin
          din_sh_d = din;
          dly_sh_d = dly;
          k_d      = {CW{1'b0}};
          state_d  = ST_RD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RD: begin
        // Ring offset wraps naturally in depth-bit arithmetic and stays in this channel's region.
        mem_re_s   = 1'b1;
        mem_addr_s = {k_q, wrpos_q - cur_dly_s};
        state_d    = ST_WR;
      end
      ST_WR: begin
        mem_we_s   = 1'b1;
        mem_addr_s = {k_q, wrpos_q};
        out_d[int'(k_q)*dw +: dw] = new_out_s;
        if (k_q == CW'(NCH - 1)) begin
          // The last channel is captured on the same edge that publishes dout.
          dout_d       = out_d;
          dout_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          k_d     = k_q + CW'(1);
          state_d = ST_RD;
        end
      end
      ST_DONE: begin
        wrpos_d = wrpos_q + depth'(1);
        if (fill_q != {depth{1'b1}}) begin
          fill_d = fill_q + depth'(1);
        end else begin
          fill_d = fill_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cen && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers. Reset also aborts any round in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= {CW{1'b0}};
      din_sh_q     <= {(NCH*dw){1'b0}};
      dly_sh_q     <= {(NCH*depth){1'b0}};
      out_q        <= {(NCH*dw){1'b0}};
      dout_q       <= {(NCH*dw){1'b0}};
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      wrpos_q      <= {depth{1'b0}};
      fill_q       <= {depth{1'b0}};
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      din_sh_q     <= din_sh_d;
      dly_sh_q     <= dly_sh_d;
      out_q        <= out_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      wrpos_q      <= wrpos_d;
      fill_q       <= fill_d;
    end
  end

  // Single-port RAM with registered read. Contents are never cleared.
  // Writes are blocked in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem_q[mem_addr_s] <= cur_din_s;
    end
    if (mem_re_s) begin
      rd_data_q <= mem_q[mem_addr_s];
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
